// File: rtl/ahb_cmd_master.sv
// Command FIFO feeding a pipelined zero-wait AHB master: one NONSEQ per cycle,
// data phase one cycle behind, read data returned as a single-cycle pulse.
module ahb_cmd_master #(
  parameter int ADDR_W     = 21,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [DATA_W-1:0] HWDATA,
  output logic [1:0]        HTRANS,
  input  logic [DATA_W-1:0] HRDATA
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              fifo_write [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_wdata [FIFO_DEPTH];

  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_idx, rd_idx;
  logic             empty, full, push, pop;
  logic             ap_nonseq;
  logic [DATA_W-1:0] ap_wdata;
  logic             dp_valid, dp_write;

  assign wr_idx    = wr_ptr[PTR_W-1:0];
  assign rd_idx    = rd_ptr[PTR_W-1:0];
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);
  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;
  assign pop       = ~empty;
  assign ap_nonseq = (HTRANS == TR_NONSEQ);
  assign busy      = ~empty | ap_nonseq | dp_valid;

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge HCLK) begin
    if (push) begin
      fifo_write[wr_idx] <= cmd_write;
      fifo_addr[wr_idx]  <= cmd_addr;
      fifo_wdata[wr_idx] <= cmd_wdata;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Address phase: HADDR/HWRITE hold their last value while idle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HTRANS   <= TR_IDLE;
      HADDR    <= '0;
      HWRITE   <= 1'b0;
      ap_wdata <= '0;
    end else if (pop) begin
      HTRANS   <= TR_NONSEQ;
      HADDR    <= fifo_addr[rd_idx];
      HWRITE   <= fifo_write[rd_idx];
      ap_wdata <= fifo_wdata[rd_idx];
    end else begin
      HTRANS   <= TR_IDLE;
    end
  end

  // Data phase; HRDATA is only looked at while a read data phase is active.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid  <= 1'b0;
      dp_write  <= 1'b0;
      HWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      dp_valid  <= ap_nonseq;
      dp_write  <= HWRITE;
      if (ap_nonseq && HWRITE) HWDATA <= ap_wdata;
      rsp_valid <= dp_valid & ~dp_write;
      if (dp_valid && !dp_write) rsp_rdata <= HRDATA;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else if (pop) begin
      if (fifo_write[rd_idx] && (wr_cnt != CNT_MAX)) wr_cnt <= wr_cnt + 1'b1;
      if (!fifo_write[rd_idx] && (rd_cnt != CNT_MAX)) rd_cnt <= rd_cnt + 1'b1;
    end
  end

endmodule
